imem_loader: RTL and testbench

- Writer side of the instruction-memory byte array: accepts 32-bit instruction words over a valid/ready stream and writes them little-endian, one byte per cycle, into the byte-wide instruction store.
- Holds the core in reset (Core_Hold) until a load completes.
- Lets programs be loaded at run time instead of from an initial block.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_byte_serializer.sv | 54 +++++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and sizing constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int MEM_BYTES_DEFAULT = 132;
   localparam int WORD_BYTES        = 4;

endpackage

// File: rtl/imem_byte_serializer.sv
// Latches one 32-bit word and emits it little-endian as 4 registered byte writes, first byte
// the cycle after load; it never stalls, so the caller must not load while a word is in flight.
module imem_byte_serializer
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic [31:0]       word,
   output logic              last_byte,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);

   logic [31:0]       word_q;
   logic [ADDR_W-1:0] base_q;
   logic [1:0]        idx;
   logic [1:0]        next_idx;

   assign next_idx  = idx + 2'd1;
   assign last_byte = wr_en && (idx == 2'(WORD_BYTES - 1));

   // Address and data are only updated while strobing, so they hold their last values when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q  <= '0;
         base_q  <= '0;
         idx     <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (load) begin
         word_q  <= word;
         base_q  <= base;
         idx     <= '0;
         wr_en   <= 1'b1;
         wr_addr <= base;
         wr_data <= word[7:0];
      end else if (wr_en) begin
         if (last_byte) begin
            wr_en <= 1'b0;
         end else begin
            idx     <= next_idx;
            wr_addr <= base_q + ADDR_W'(next_idx);
            wr_data <= 8'(word_q >> {next_idx, 3'b000});
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Run-time instruction loader: stream words in, 4 byte writes each (5 cycles/word), Core_Hold until done.
// Load_Ready is low while a word is being written; IMEM_LOADER_CHECKSUM_EN adds the running word sum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Start,
   input  logic [31:0]       Load_Word,
   input  logic              Load_Valid,
   input  logic              Load_Last,
   output logic              Load_Ready,
   output logic              Mem_Write_En,
   output logic [ADDR_W-1:0] Mem_Write_Addr,
   output logic [7:0]        Mem_Write_Data,
   output logic              Core_Hold,
   output logic              Load_Done,
   output logic              Load_Error,
   output logic [31:0]       Checksum
);

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic              last_q;
   logic              accept;
   logic              overflow;
   logic              load;
   logic              start_go;
   logic              last_byte;

   assign accept   = (state == S_RECV) && Load_Valid && Load_Ready;
   assign overflow = (base + ADDR_W'(WORD_BYTES)) > ADDR_W'(MEM_BYTES);
   assign load     = accept && !overflow;
   assign start_go = Start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

   imem_byte_serializer #(.ADDR_W(ADDR_W)) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .base      (base),
      .word      (Load_Word),
      .last_byte (last_byte),
      .wr_en     (Mem_Write_En),
      .wr_addr   (Mem_Write_Addr),
      .wr_data   (Mem_Write_Data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         base       <= '0;
         last_q     <= 1'b0;
         Load_Ready <= 1'b0;
         Core_Hold  <= 1'b1;
         Load_Done  <= 1'b0;
         Load_Error <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  state      <= S_RECV;
                  base       <= '0;
                  Load_Ready <= 1'b1;
               end
            end
            S_RECV: begin
               if (accept) begin
                  Load_Ready <= 1'b0;
                  if (overflow) begin
                     // Word does not fit: drop it and park with the core still held.
                     state      <= S_ERROR;
                     Load_Error <= 1'b1;
                  end else begin
                     state  <= S_WRITE;
                     last_q <= Load_Last;
                  end
               end
            end
            S_WRITE: begin
               if (last_byte) begin
                  if (last_q) begin
                     state     <= S_DONE;
                     Load_Done <= 1'b1;
                     Core_Hold <= 1'b0;
                  end else begin
                     state      <= S_RECV;
                     base       <= base + ADDR_W'(WORD_BYTES);
                     Load_Ready <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (Start) begin
                  state      <= S_RECV;
                  base       <= '0;
                  Load_Done  <= 1'b0;
                  Core_Hold  <= 1'b1;
                  Load_Ready <= 1'b1;
               end
            end
            S_ERROR: begin
               if (Start) begin
                  state      <= S_RECV;
                  base       <= '0;
                  Load_Error <= 1'b0;
                  Load_Ready <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Checksum <= '0;
      end else if (start_go) begin
         Checksum <= '0;
      end else if (load) begin
         Checksum <= Checksum + Load_Word;
      end
   end
`else
   assign Checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected byte writes are queued at each handshake and matched by a monitor.
module tb_imem_loader;

   localparam int MEM    = 132;
   localparam int ADDR_W = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              Start;
   logic [31:0]       Load_Word;
   logic              Load_Valid;
   logic              Load_Last;
   logic              Load_Ready;
   logic              Mem_Write_En;
   logic [ADDR_W-1:0] Mem_Write_Addr;
   logic [7:0]        Mem_Write_Data;
   logic              Core_Hold;
   logic              Load_Done;
   logic              Load_Error;
   logic [31:0]       Checksum;

   imem_loader #(.MEM_BYTES(MEM), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .Start          (Start),
      .Load_Word      (Load_Word),
      .Load_Valid     (Load_Valid),
      .Load_Last      (Load_Last),
      .Load_Ready     (Load_Ready),
      .Mem_Write_En   (Mem_Write_En),
      .Mem_Write_Addr (Mem_Write_Addr),
      .Mem_Write_Data (Mem_Write_Data),
      .Core_Hold      (Core_Hold),
      .Load_Done      (Load_Done),
      .Load_Error     (Load_Error),
      .Checksum       (Checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      int                at;
   } wr_t;

   wr_t               exp_q[$];
   int                compared   = 0;
   int                mismatched = 0;
   int                cyc        = 0;
   int                hs_cyc     = 0;
   logic [ADDR_W-1:0] tb_base    = '0;
   logic [31:0]       exp_cs     = '0;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [31:0] cs_expect();
`ifdef IMEM_LOADER_CHECKSUM_EN
      return exp_cs;
`else
      return 32'h0;
`endif
   endfunction

   // Every strobe must match the oldest queued byte in address, data and cycle.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (Mem_Write_En === 1'b1) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_write addr=%0h data=%02h cyc=%0d", Mem_Write_Addr, Mem_Write_Data, cyc);
         end else begin
            e = exp_q.pop_front();
            if (Mem_Write_Addr !== e.addr || Mem_Write_Data !== e.data || cyc != e.at)
               begin
                  mismatched++;
                  $display("FAIL byte_write got addr=%0h data=%02h cyc=%0d want addr=%0h data=%02h cyc=%0d",
                           Mem_Write_Addr, Mem_Write_Data, cyc, e.addr, e.data, e.at);
               end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic do_start();
      Start = 1'b1;
      @(negedge clk);
      Start   = 1'b0;
      tb_base = '0;
      exp_cs  = '0;
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_word(input logic [31:0] w, input logic last);
      wr_t e;
      int  n;
      Load_Word  = w;
      Load_Last  = last;
      Load_Valid = 1'b1;
      n = 0;
      while (Load_Ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         compared++;
         mismatched++;
         $display("FAIL ready_timeout word=%08h", w);
         Load_Valid = 1'b0;
         return;
      end
      hs_cyc = cyc + 1;
      if (tb_base + 4 <= MEM) begin
         for (int i = 0; i < 4; i++) begin
            e.addr = tb_base + ADDR_W'(i);
            e.data = 8'(w >> (8 * i));
            e.at   = hs_cyc + i;
            exp_q.push_back(e);
         end
         tb_base = tb_base + 4;
         exp_cs  = exp_cs + w;
      end
      @(negedge clk);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (Load_Done !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (Load_Done !== 1'b1 || Core_Hold !== 1'b0 || Load_Error !== 1'b0 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL done_state got done=%b hold=%b err=%b pending=%0d want done=1 hold=0 err=0 pending=0",
                  Load_Done, Core_Hold, Load_Error, exp_q.size());
      end
   endtask

   task automatic check_reset_state(input string tag);
      compared++;
      if ({Load_Ready, Mem_Write_En, Core_Hold, Load_Done, Load_Error} !== 5'b00100) begin
         mismatched++;
         $display("FAIL %s_flags got rdy/en/hold/done/err=%b want 00100", tag,
                  {Load_Ready, Mem_Write_En, Core_Hold, Load_Done, Load_Error});
      end
      compared++;
      if (Mem_Write_Addr !== '0 || Mem_Write_Data !== 8'h00 || Checksum !== 32'h0) begin
         mismatched++;
         $display("FAIL %s_data got addr=%0h data=%02h cs=%08h want 0/00/00000000", tag,
                  Mem_Write_Addr, Mem_Write_Data, Checksum);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; Start = 1'b0; Load_Valid = 1'b0; Load_Word = '0; Load_Last = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (Load_Ready !== 1'b0 || Core_Hold !== 1'b1) begin
         mismatched++;
         $display("FAIL idle_hold got rdy=%b hold=%b want rdy=0 hold=1", Load_Ready, Core_Hold);
      end
   endtask

   task automatic test_single_word();
      do_start();
      compared++;
      if (Load_Ready !== 1'b1 || Core_Hold !== 1'b1) begin
         mismatched++;
         $display("FAIL recv_entry got rdy=%b hold=%b want rdy=1 hold=1", Load_Ready, Core_Hold);
      end
      send_word(32'h00300293, 1'b1);
      Load_Valid = 1'b0;
      compared++;
      if (Load_Ready !== 1'b0 || Mem_Write_En !== 1'b1) begin
         mismatched++;
         $display("FAIL write_phase got rdy=%b en=%b want rdy=0 en=1", Load_Ready, Mem_Write_En);
      end
      wait_done();
      compared++;
      if (Checksum !== cs_expect()) begin
         mismatched++;
         $display("FAIL single_checksum got %08h want %08h", Checksum, cs_expect());
      end
   endtask

   task automatic test_back_to_back();
      int h1;
      do_start();
      compared++;
      if (Load_Done !== 1'b0 || Core_Hold !== 1'b1) begin
         mismatched++;
         $display("FAIL restart_from_done got done=%b hold=%b want done=0 hold=1", Load_Done, Core_Hold);
      end
      send_word(32'h00300293, 1'b0);
      h1 = hs_cyc;
      send_word(32'h00523223, 1'b1);
      Load_Valid = 1'b0;
      compared++;
      if (hs_cyc - h1 != 5) begin
         mismatched++;
         $display("FAIL handshake_spacing got %0d want 5", hs_cyc - h1);
      end
      wait_done();
   endtask

   task automatic test_overflow();
      do_start();
      for (int i = 0; i < MEM / 4; i++) send_word(32'h01010101 * (i + 1), 1'b0);
      send_word(32'hDEADBEEF, 1'b1);
      Load_Valid = 1'b0;
      repeat (6) @(negedge clk);
      compared++;
      if ({Load_Error, Core_Hold, Load_Done, Load_Ready} !== 4'b1100 || exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL overflow_state got err/hold/done/rdy=%b pending=%0d want 1100 pending=0",
                  {Load_Error, Core_Hold, Load_Done, Load_Ready}, exp_q.size());
      end
      compared++;
      if (Mem_Write_Addr !== ADDR_W'(MEM - 1) || Checksum !== cs_expect()) begin
         mismatched++;
         $display("FAIL overflow_hold got addr=%0h cs=%08h want addr=%0h cs=%08h",
                  Mem_Write_Addr, Checksum, MEM - 1, cs_expect());
      end
   endtask

   task automatic test_restart();
      do_start();
      compared++;
      if (Load_Error !== 1'b0 || Load_Ready !== 1'b1 || Core_Hold !== 1'b1) begin
         mismatched++;
         $display("FAIL restart_from_error got err=%b rdy=%b hold=%b want 0/1/1", Load_Error, Load_Ready, Core_Hold);
      end
      send_word(32'h00000013, 1'b1);
      Load_Valid = 1'b0;
      wait_done();
      do_start();
      compared++;
      if (Load_Done !== 1'b0) begin
         mismatched++;
         $display("FAIL done_deassert got %b want 0", Load_Done);
      end
      send_word(32'h00000013, 1'b1);
      Load_Valid = 1'b0;
      wait_done();
   endtask

   task automatic test_checksum();
      logic [31:0] want;
`ifdef IMEM_LOADER_CHECKSUM_EN
      want = 32'h00000001;
`else
      want = 32'h00000000;
`endif
      do_start();
      send_word(32'hFFFFFFFF, 1'b0);
      send_word(32'h00000002, 1'b1);
      Load_Valid = 1'b0;
      wait_done();
      compared++;
      if (Checksum !== want) begin
         mismatched++;
         $display("FAIL checksum_wrap got %08h want %08h", Checksum, want);
      end
   endtask

   task automatic test_mid_reset();
      do_start();
      send_word(32'hA1B2C3D4, 1'b1);
      Load_Valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      compared++;
      if (Mem_Write_En !== 1'b0) begin
         mismatched++;
         $display("FAIL async_abort got en=%b want 0", Mem_Write_En);
      end
      exp_q.delete();
      tb_base = '0;
      exp_cs  = '0;
      repeat (3) @(negedge clk);
      check_reset_state("midreset");
      reset = 1'b1;
      repeat (8) @(negedge clk);
      compared++;
      if (Load_Ready !== 1'b0 || Core_Hold !== 1'b1 || Load_Done !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_idle got rdy=%b hold=%b done=%b want 0/1/0", Load_Ready, Core_Hold, Load_Done);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_restart();
      test_checksum();
      test_mid_reset();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL leftover_writes got %0d want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
